sn_result_uart_tx: RTL
======================

# sn_result_uart_tx

Downstream stage of the stochastic multiplier. It captures each 10-bit window result (overflow flag plus 9-bit bipolar probability) and converts the probability to a signed two's-complement value. It then transmits the result as a framed, parity-protected serial word on one output pin, so that a single pin carries every multiplier result off-chip. A one-deep pending buffer absorbs a result that arrives during transmission, and a saturating counter records results lost to overrun.

## Interface
Parameters:
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range ≥ 2.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous, active-high despite the name. Sampled on the rising edge of clk.
- res_in  in  10  multiplier result. [9] is the overflow flag; [8:0] is the bipolar probability p, 0..511.
- res_valid  in  1  one-cycle strobe. The multiplier asserts it in the cycle after it updates its result register.
- tx  out  1  serial line. Idles high.
- busy  out  1  high while a frame is being shifted or a result is pending.
- drop_cnt  out  4  count of overwritten results. Saturates at 15.

## Operation
- Conversion, applied at capture: s[9:0] = {1'b0,p} − 10'd256, signed, range −256..+255.
  - p = 256 maps to 0.
  - p = 0 maps to −256 (10'h300).
  - p = 511 maps to +255.
- Payload, 11 bits: s[9:0], then ovf = res_in[9].
- Parity: even parity over the 11 payload bits (XOR of the payload).
- Frame, 14 bits, sent LSB first:
  - bit 0: start bit, 0.
  - bits 1–10: s[0]..s[9].
  - bit 11: ovf.
  - bit 12: parity.
  - bit 13: stop bit, 1.
- FSM states: IDLE → START → DATA (12 bits: s, ovf, parity) → STOP → IDLE, or → START directly if a result is pending.
- Pending buffer: one entry holding a converted 12-bit word (s, ovf, parity).
  - res_valid in IDLE with the buffer empty: the word is written to the buffer, and the FSM loads it at the next edge.
  - res_valid while a frame is active and the buffer is empty: the word is stored in the buffer.
  - res_valid while a frame is active and the buffer is full: the new word overwrites the buffer and drop_cnt increments (saturating at 15).
- busy = (state != IDLE) | pending_full.

## Timing
- Reset values: tx = 1, busy = 0, drop_cnt = 0, pending buffer empty, FSM in IDLE, bit and cycle counters at 0.
- Reset asserted mid-frame aborts the frame. tx is 1 from the cycle after the reset edge, and the pending word is discarded.
- Latency, idle case: res_valid sampled high at edge t → tx = 0 (start bit) from edge t+2, with busy high from edge t+1.
- Each bit is held for exactly CLKS_PER_BIT cycles. A full frame lasts 14·CLKS_PER_BIT cycles.
- Back-to-back frames: if the buffer is full when the stop bit completes, the next start bit begins on the following cycle, with no idle gap.
- Simultaneous res_valid and stop-bit completion with the buffer full: the buffered word moves to the shifter and the new word enters the buffer. No drop is counted.
- Simultaneous res_valid and stop-bit completion with the buffer empty: the new word enters the buffer and its frame starts one cycle later.
- res_valid while rst_n is high is ignored.
- The multiplier's result period is 131073 cycles, far longer than one frame, so overrun occurs only under test stimulus.

## Test plan
- Reset with rst_n = 1 for 3 cycles → tx = 1, busy = 0, drop_cnt = 0. tx stays 1 for 100 idle cycles.
- CLKS_PER_BIT = 4, res_in = 10'h100 → frame bits 0, 0×10, 0, 0, 1. Each bit is 4 cycles and the frame is 56 cycles total; busy falls after the stop bit.
- res_in = 10'h000 → s = 10'h300. Data bits LSB-first are 0000000011, then ovf 0, parity 0.
- res_in = 10'h3FF → s = 10'h0FF and ovf = 1. Data bits are 1111111100, then ovf 1, parity 1.
- Three res_valid strobes 5 cycles apart with values A, B, C → frame A is sent, then frame C immediately back-to-back. B is lost and drop_cnt = 1.
- Assert rst_n at cycle 20 of a frame while a word is pending → tx = 1 from the next cycle, busy = 0, and no further frame is sent.

Source files
------------

// File: rtl/sn_result_uart_tx.sv
// sn_result_uart_tx: serialises multiplier results as 14-bit parity frames on tx (clk, rst_n sync active-high; res_in/res_valid in; tx, busy, drop_cnt out)
module sn_result_uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] res_in,
  input  logic       res_valid,
  output logic       tx,
  output logic       busy,
  output logic [3:0] drop_cnt
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cyc;
  logic [3:0] bit_cnt;
  logic [11:0] sh, pend, w_in;
  logic [9:0] s;
  logic pend_full, bit_done, load;
  assign s = {1'b0, res_in[8:0]} - 10'd256;
  assign w_in = {^{res_in[9], s}, res_in[9], s};
  assign bit_done = state != IDLE && cyc == CW'(CLKS_PER_BIT - 1);
  assign load = pend_full && (state == IDLE || (state == STOP && bit_done));
  always_comb begin
    state_n = state;
    state_n = load ? START
            : !bit_done ? state
            : state == START ? DATA
            : state == DATA ? (bit_cnt == 4'd11 ? STOP : DATA)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      cyc <= '0;
      bit_cnt <= '0;
      sh <= '0;
      pend <= '0;
      pend_full <= 1'b0;
      drop_cnt <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cyc <= (state == IDLE || bit_done) ? '0 : cyc + CW'(1);
      bit_cnt <= state != DATA ? 4'd0 : bit_done ? bit_cnt + 4'd1 : bit_cnt;
      sh <= load ? pend : (state == DATA && bit_done) ? sh >> 1 : sh;
      pend <= res_valid ? w_in : pend;
      pend_full <= res_valid | (pend_full & ~load);
      drop_cnt <= (res_valid && pend_full && !load && drop_cnt != 4'd15) ? drop_cnt + 4'd1 : drop_cnt;
      tx <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
      busy <= state != IDLE || pend_full;
    end
  end
endmodule
